// File: rtl/mem_bus_arbiter.sv
// Shared memory-port arbiter between instruction fetch (ibus) and load/store (dbus).
// Alternating priority on contention, fully registered memory interface,
// one-cycle completion pulses and a grant-state watchdog that aborts hung accesses.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ibus_req,
  input  logic [31:0] ibus_addr,
  output logic [31:0] ibus_rdata,
  output logic        ibus_ack,
  input  logic        dbus_req,
  input  logic        dbus_we,
  input  logic [3:0]  dbus_sel,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_wdata,
  output logic [31:0] dbus_rdata,
  output logic        dbus_ack,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_req_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  // Abort fires at the end of the TIMEOUT-th cycle spent in a grant state.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        ce_q, ce_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        iack_q, iack_d;
  logic        dack_q, dack_d;
  logic        err_q, err_d;

  // Next-state, arbitration, completion capture and watchdog abort.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    wdog_d   = wdog_q;
    ce_d     = ce_q;
    we_d     = we_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // Fetch wins contention only if data had the previous grant.
        if (ibus_req && (!dbus_req || last_d_q)) begin
          state_d  = GRANT_I;
          last_d_d = 1'b0;
          wdog_d   = 8'd0;
          ce_d     = 1'b1;
          we_d     = 1'b0;
          sel_d    = 4'b1111;
          addr_d   = ibus_addr;
          wdata_d  = 32'd0;
        end else if (dbus_req) begin
          state_d  = GRANT_D;
          last_d_d = 1'b1;
          wdog_d   = 8'd0;
          ce_d     = 1'b1;
          we_d     = dbus_we;
          sel_d    = dbus_sel;
          addr_d   = dbus_addr;
          wdata_d  = dbus_wdata;
        end
      end
      GRANT_I, GRANT_D: begin
        // A late ack in the final watchdog cycle still completes normally.
        if (mem_ack_i) begin
          state_d = RESP;
          ce_d    = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'b0000;
          if (state_q == GRANT_I) begin
            irdata_d = mem_rdata_i;
            iack_d   = 1'b1;
          end else begin
            drdata_d = we_q ? 32'd0 : mem_rdata_i;
            dack_d   = 1'b1;
          end
        end else if (wdog_q == WD_LAST) begin
          state_d = RESP;
          ce_d    = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'b0000;
          addr_d  = 32'd0;
          wdata_d = 32'd0;
          err_d   = 1'b1;
          if (state_q == GRANT_I) begin
            irdata_d = 32'd0;
            iack_d   = 1'b1;
          end else begin
            drdata_d = 32'd0;
            dack_d   = 1'b1;
          end
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      wdog_q   <= 8'd0;
      ce_q     <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= 4'b0000;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      irdata_q <= 32'd0;
      drdata_q <= 32'd0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wdog_q   <= wdog_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
      err_q    <= err_d;
    end
  end

  assign mem_ce_o    = ce_q;
  assign mem_we_o    = we_q;
  assign mem_sel_o   = sel_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign ibus_rdata  = irdata_q;
  assign dbus_rdata  = drdata_q;
  assign ibus_ack    = iack_q;
  assign dbus_ack    = dack_q;
  assign bus_err_o   = err_q;

  // Stall while any request is waiting for its completion pulse.
  assign stall_req_o = !rst && ((ibus_req && !iack_q) || (dbus_req && !dack_q));

endmodule
